// File: rtl/tx_pkt_sched_pkg.sv
// Shared types for the TX packet scheduler.
// State and error encodings plus datapath widths.
package tx_sched_pkg;

  localparam int DW   = 8;
  localparam int LENW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_RD,
    S_LEN_WAIT,
    S_BYTE_RD,
    S_BYTE_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_NOT_READY = 2'd1,
    ERR_BAD_LEN   = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } err_code_t;

endpackage

// File: rtl/tx_pkt_sched_if.sv
// Valid/ready byte stream toward the modem/DAC path.
// Master drives data/valid/last, slave drives ready.
interface tx_pkt_sched_if;

  logic [tx_sched_pkg::DW-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/tx_pkt_sched.sv
// TX FIFO read arbiter and packet sequencer.
// Streams one stored packet per start; host reads pass only in IDLE.
module tx_pkt_sched
  import tx_sched_pkg::*;
#(
  parameter int MAX_LEN     = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            host_rd_en,
  input  logic            host_len_rd_en,
  output logic            fifo_rd_en,
  output logic            fifo_len_rd_en,
  input  logic [DW-1:0]   fifo_data,
  input  logic [LENW-1:0] fifo_len,
  input  logic            fifo_full,
  tx_pkt_sched_if.master  m,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [LENW-1:0] byte_cnt,
  output logic            host_blocked
);

  localparam int SW = $clog2(TIMEOUT_CYC + 1);

  state_t          r_state;
  state_t          w_next;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_cnt;
  logic [SW-1:0]   r_stall;
  logic [DW-1:0]   r_data;
  logic            r_valid;
  logic            r_err;
  err_code_t       r_code;
  logic            r_hblk;

  logic            w_host;
  logic            w_in_send;
  logic            w_hs;
  logic            w_tmo;
  logic            w_len_bad;
  logic            w_cnt_last;
  logic [LENW-1:0] w_cnt_inc;

  assign w_host     = host_rd_en | host_len_rd_en;
  assign w_in_send  = (r_state == S_SEND);
  assign w_hs       = w_in_send & m.m_ready;
  assign w_tmo      = w_in_send & ~m.m_ready &
                      (r_stall == SW'(TIMEOUT_CYC - 1));
  assign w_len_bad  = (fifo_len == '0) |
                      (fifo_len > LENW'(MAX_LEN));
  assign w_cnt_inc  = r_cnt + LENW'(1);
  assign w_cnt_last = (w_cnt_inc == r_len);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    fifo_rd_en     = 1'b0;
    fifo_len_rd_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        fifo_rd_en     = host_rd_en & ~start;
        fifo_len_rd_en = host_len_rd_en & ~start;
        if (start & fifo_full) w_next = S_LEN_RD;
      end
      S_LEN_RD: begin
        fifo_len_rd_en = 1'b1;
        w_next         = S_LEN_WAIT;
      end
      S_LEN_WAIT: begin
        w_next = w_len_bad ? S_IDLE : S_BYTE_RD;
      end
      S_BYTE_RD: begin
        fifo_rd_en = 1'b1;
        w_next     = S_BYTE_WAIT;
      end
      S_BYTE_WAIT: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs)       w_next = w_cnt_last ? S_DONE : S_BYTE_RD;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Keep the FIFO quiet while reset is held.
    if (reset) begin
      fifo_rd_en     = 1'b0;
      fifo_len_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_cnt   <= '0;
      r_stall <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
      r_hblk  <= 1'b0;
    end else begin
      // A strobe coinciding with start in IDLE is dropped too.
      r_hblk <= w_host & ((r_state != S_IDLE) | start);
      unique case (r_state)
        S_IDLE: begin
          if (start & fifo_full) begin
            r_err   <= 1'b0;
            r_code  <= ERR_NONE;
            r_cnt   <= '0;
            r_stall <= '0;
          end else if (start) begin
            r_err  <= 1'b1;
            r_code <= ERR_NOT_READY;
          end
        end
        S_LEN_WAIT: begin
          r_len <= fifo_len;
          if (w_len_bad) begin
            r_err  <= 1'b1;
            r_code <= ERR_BAD_LEN;
          end
        end
        S_BYTE_WAIT: begin
          r_data  <= fifo_data;
          r_valid <= 1'b1;
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            r_cnt   <= w_cnt_inc;
            r_stall <= '0;
          end else if (w_tmo) begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
            r_code  <= ERR_TIMEOUT;
            r_stall <= '0;
          end else begin
            r_stall <= r_stall + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m.m_data     = r_data;
  assign m.m_valid    = r_valid;
  assign m.m_last     = w_in_send & (r_cnt == r_len - LENW'(1));
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;
  assign err_code     = r_code;
  assign byte_cnt     = r_cnt;
  assign host_blocked = r_hblk;

endmodule

// File: tb/tb_tx_pkt_sched.sv
// Self-checking bench for tx_pkt_sched.
// FIFO and downstream sink are modelled here; expectations come from packet contents.
module tb_tx_pkt_sched;

  localparam int MAXL = 64;
  localparam int TMO  = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       host_rd_en;
  logic       host_len_rd_en;
  logic       fifo_rd_en;
  logic       fifo_len_rd_en;
  logic [7:0] fifo_data;
  logic [7:0] fifo_len;
  logic       fifo_full;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] byte_cnt;
  logic       host_blocked;

  tx_pkt_sched_if mif();

  tx_pkt_sched #(
    .MAX_LEN     (MAXL),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .host_rd_en     (host_rd_en),
    .host_len_rd_en (host_len_rd_en),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_len_rd_en (fifo_len_rd_en),
    .fifo_data      (fifo_data),
    .fifo_len       (fifo_len),
    .fifo_full      (fifo_full),
    .m              (mif.master),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code),
    .byte_cnt       (byte_cnt),
    .host_blocked   (host_blocked)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] lenq[$];
  logic [7:0] dataq[$];
  logic [7:0] pkt[$];

  // FIFO model: registered outputs, valid the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_len_rd_en) begin
      if (lenq.size() > 0) fifo_len <= lenq.pop_front();
      else                 fifo_len <= 8'h00;
    end
    if (fifo_rd_en) begin
      if (dataq.size() > 0) fifo_data <= dataq.pop_front();
      else                  fifo_data <= 8'h00;
    end
  end

  logic [7:0] obs_b[$];
  bit         obs_l[$];
  int n_done, n_len_rd, n_rd, n_stall;
  int n_unst, n_drop, n_hb, n_busy, fv;
  bit expired;

  task automatic load(input int len, input bit rnd);
    lenq.delete();
    dataq.delete();
    pkt.delete();
    lenq.push_back(8'(len));
    for (int i = 0; i < len; i++)
      pkt.push_back(rnd ? 8'($urandom) : 8'(i + 1));
    foreach (pkt[i]) dataq.push_back(pkt[i]);
    fifo_full = 1'b1;
  endtask

  // Start a packet and record what the sink sees until IDLE.
  task automatic xfer(input int budget, input int pct,
                      input int s_idx, input int s_n,
                      input int poke);
    bit seen, pv, poked, r;
    logic [7:0] pd;
    int st, idx;
    seen = 0; pv = 0; poked = 0; st = 0; idx = 0;
    pd = 8'h00;
    obs_b.delete();
    obs_l.delete();
    n_done = 0; n_len_rd = 0; n_rd = 0; n_stall = 0;
    n_unst = 0; n_drop = 0; n_hb = 0; n_busy = 0;
    fv = -1; expired = 1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      host_rd_en = 1'b0;
      if (mif.m_valid && idx == s_idx && st < s_n) r = 0;
      else r = ($urandom_range(99) < pct);
      mif.m_ready = r;
      if (poke != 0 && mif.m_valid && !poked) begin
        poked = 1;
        if (poke == 1) host_rd_en = 1'b1;
        else           start = 1'b1;
      end
      #1;
      if (busy) begin seen = 1; n_busy++; end
      if (fifo_len_rd_en) n_len_rd++;
      if (fifo_rd_en) n_rd++;
      if (host_blocked) n_hb++;
      if (done) n_done++;
      if (pv) begin
        if (!mif.m_valid) n_drop++;
        else if (mif.m_data !== pd) n_unst++;
      end
      pv = 0;
      if (mif.m_valid) begin
        if (fv < 0) fv = c;
        if (r) begin
          obs_b.push_back(mif.m_data);
          obs_l.push_back(mif.m_last);
          idx++;
          st = 0;
        end else begin
          n_stall++;
          st++;
          pv = 1;
          pd = mif.m_data;
        end
      end
      if (seen && !busy) begin expired = 0; break; end
    end
    start = 1'b0;
    host_rd_en = 1'b0;
    mif.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    v = {fifo_rd_en, fifo_len_rd_en, mif.m_data,
         mif.m_valid, mif.m_last, busy, done, err,
         err_code, byte_cnt, host_blocked};
    n_chk++;
    if (v !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h exp 0", v);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    load(3, 0);
    xfer(100, 100, -1, 0, 0);
    n_chk++;
    if (expired) begin n_fail++; $display("FAIL basic_budget: expired"); end
    n_chk++;
    if (obs_b.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d exp 3", obs_b.size());
    end
    for (int i = 0; i < obs_b.size() && i < 3; i++) begin
      n_chk++;
      if (obs_b[i] !== pkt[i] || obs_l[i] !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h/%0d exp %h/%0d",
                 i, obs_b[i], obs_l[i], pkt[i], i == 2);
      end
    end
    n_chk++;
    if (n_done != 1 || byte_cnt !== 8'd3 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: done=%0d cnt=%0d err=%b exp 1 3 0",
               n_done, byte_cnt, err);
    end
    n_chk++;
    if (n_len_rd != 1 || n_rd != 3) begin
      n_fail++;
      $display("FAIL basic_strobes: len=%0d rd=%0d exp 1 3",
               n_len_rd, n_rd);
    end
    n_chk++;
    if (fv != 4 || n_busy != 12) begin
      n_fail++;
      $display("FAIL basic_timing: fv=%0d busy=%0d exp 4 12",
               fv, n_busy);
    end
  endtask

  task automatic test_not_ready();
    int nb, ns;
    nb = 0; ns = 0;
    lenq.delete();
    dataq.delete();
    fifo_full = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (busy) nb++;
      if (fifo_rd_en || fifo_len_rd_en) ns++;
    end
    n_chk++;
    if (nb != 0 || ns != 0) begin
      n_fail++;
      $display("FAIL nr_idle: busy=%0d strobes=%0d exp 0 0", nb, ns);
    end
    n_chk++;
    if (err !== 1'b1 || err_code !== 2'd1) begin
      n_fail++;
      $display("FAIL nr_err: got %b/%0d exp 1/1", err, err_code);
    end
    load(4, 1);
    xfer(100, 100, -1, 0, 0);
    n_chk++;
    if (err !== 1'b0 || err_code !== 2'd0 || obs_b.size() != 4) begin
      n_fail++;
      $display("FAIL nr_recover: err=%b code=%0d n=%0d exp 0 0 4",
               err, err_code, obs_b.size());
    end
  endtask

  task automatic test_bad_len();
    int lens[2];
    lens[0] = 0;
    lens[1] = MAXL + 1;
    foreach (lens[k]) begin
      load(lens[k], 1);
      xfer(50, 100, -1, 0, 0);
      n_chk++;
      if (n_len_rd != 1 || n_rd != 0 || obs_b.size() != 0) begin
        n_fail++;
        $display("FAIL badlen%0d_strobes: len=%0d rd=%0d exp 1 0",
                 lens[k], n_len_rd, n_rd);
      end
      n_chk++;
      if (err !== 1'b1 || err_code !== 2'd2 || n_done != 0) begin
        n_fail++;
        $display("FAIL badlen%0d_err: got %b/%0d exp 1/2",
                 lens[k], err, err_code);
      end
      n_chk++;
      if (expired || n_busy > 3) begin
        n_fail++;
        $display("FAIL badlen%0d_idle: busy=%0d exp <=3",
                 lens[k], n_busy);
      end
    end
  endtask

  task automatic test_stall();
    load(3, 0);
    xfer(200, 100, 1, 10, 0);
    n_chk++;
    if (n_stall != 10 || n_unst != 0 || n_drop != 0) begin
      n_fail++;
      $display("FAIL stall_hold: st=%0d unst=%0d drop=%0d exp 10 0 0",
               n_stall, n_unst, n_drop);
    end
    n_chk++;
    if (obs_b.size() != 3 || n_done != 1) begin
      n_fail++;
      $display("FAIL stall_count: n=%0d done=%0d exp 3 1",
               obs_b.size(), n_done);
    end else if (obs_b[1] !== 8'h02 || obs_b[2] !== 8'h03) begin
      n_chk++;
      n_fail++;
      $display("FAIL stall_data: got %h %h exp 02 03",
               obs_b[1], obs_b[2]);
    end
  endtask

  task automatic test_timeout();
    load(3, 1);
    xfer(400, 0, -1, 0, 0);
    n_chk++;
    if (expired || n_stall != TMO || n_drop != 1) begin
      n_fail++;
      $display("FAIL tmo_cycles: st=%0d drop=%0d exp %0d 1",
               n_stall, n_drop, TMO);
    end
    n_chk++;
    if (err !== 1'b1 || err_code !== 2'd3 || n_done != 0) begin
      n_fail++;
      $display("FAIL tmo_err: got %b/%0d done=%0d exp 1/3 0",
               err, err_code, n_done);
    end
  endtask

  task automatic test_host();
    logic [23:0] v;
    int dn;
    bit got;
    logic [7:0] first;
    @(negedge clk);
    host_rd_en = 1'b1;
    host_len_rd_en = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b1 || fifo_len_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL host_idle_pass: got %b%b exp 11",
               fifo_rd_en, fifo_len_rd_en);
    end
    @(negedge clk);
    host_rd_en = 1'b0;
    host_len_rd_en = 1'b0;
    #1;
    n_chk++;
    if (host_blocked !== 1'b0) begin
      n_fail++;
      $display("FAIL host_idle_blk: got %b exp 0", host_blocked);
    end
    load(4, 1);
    xfer(100, 100, -1, 0, 1);
    n_chk++;
    if (n_hb != 1 || n_rd != 4 || obs_b.size() != 4) begin
      n_fail++;
      $display("FAIL host_send: hb=%0d rd=%0d n=%0d exp 1 4 4",
               n_hb, n_rd, obs_b.size());
    end
    load(2, 1);
    @(negedge clk);
    start = 1'b1;
    host_rd_en = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL host_start_drop: got %b exp 0", fifo_rd_en);
    end
    @(negedge clk);
    start = 1'b0;
    host_rd_en = 1'b0;
    mif.m_ready = 1'b1;
    #1;
    n_chk++;
    if (host_blocked !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL host_start_blk: hb=%b busy=%b exp 1 1",
               host_blocked, busy);
    end
    got = 0;
    first = 8'h00;
    for (int i = 0; i < 50 && busy; i++) begin
      @(negedge clk);
      #1;
      if (mif.m_valid && !got) begin got = 1; first = mif.m_data; end
    end
    n_chk++;
    if (busy || first !== pkt[0] || byte_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL host_start_pkt: first=%h cnt=%0d exp %h 2",
               first, byte_cnt, pkt[0]);
    end
    mif.m_ready = 1'b0;
    load(5, 1);
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (mif.m_valid) break;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    v = {fifo_rd_en, fifo_len_rd_en, mif.m_data,
         mif.m_valid, mif.m_last, busy, done, err,
         err_code, byte_cnt, host_blocked};
    n_chk++;
    if (v !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mid_send: got %h exp 0", v);
    end
    reset = 1'b0;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done || busy) dn++;
    end
    n_chk++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d exp 0", dn);
    end
  endtask

  task automatic test_back_to_back();
    int len, bad;
    for (int k = 0; k < 15; k++) begin
      len = (k == 0) ? MAXL : int'($urandom_range(12, 1));
      load(len, 1);
      xfer(2000, 70, -1, 0, (k % 3 == 2) ? 2 : 0);
      bad = 0;
      for (int i = 0; i < obs_b.size() && i < len; i++)
        if (obs_b[i] !== pkt[i] || obs_l[i] !== (i == len - 1))
          bad++;
      n_chk++;
      if (expired || obs_b.size() != len || bad != 0) begin
        n_fail++;
        $display("FAIL b2b%0d_stream: n=%0d bad=%0d exp %0d 0",
                 k, obs_b.size(), bad, len);
      end
      n_chk++;
      if (n_done != 1 || err !== 1'b0 || n_drop != 0 || n_unst != 0) begin
        n_fail++;
        $display("FAIL b2b%0d_status: done=%0d err=%b drop=%0d unst=%0d",
                 k, n_done, err, n_drop, n_unst);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (byte_cnt !== 8'(len) || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b%0d_hold: cnt=%0d busy=%b exp %0d 0",
                 k, byte_cnt, busy, len);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    host_rd_en = 1'b0;
    host_len_rd_en = 1'b0;
    fifo_full = 1'b0;
    fifo_data = 8'h00;
    fifo_len = 8'h00;
    mif.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_not_ready();
    test_bad_len();
    test_stall();
    test_timeout();
    test_host();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_pkt_sched.md
Name: tx_pkt_sched

Overview:
Controller and arbiter for the TX packet FIFO; it shares the FIFO read port between the SPI register path and the transmit datapath.
- On a start command, it reads the stored packet length, pops exactly that many bytes, and streams them on a valid/ready byte interface toward the modem/DAC path.
- It reports busy, done and error status back to the status register.
- Host (SPI) readback of the FIFO is passed through only while the sequencer is idle.

Parameters:
DW, 8, data byte width
LENW, 8, length field width
MAX_LEN, 64, largest legal packet length in bytes
TIMEOUT_CYC, 255, max consecutive stall cycles (m_ready low) before abort

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse from status register write, begin transmit
host_rd_en  in  1  SPI-side data read strobe for the TX FIFO
host_len_rd_en  in  1  SPI-side length read strobe for the TX FIFO
fifo_rd_en  out  1  FIFO data read strobe (arbitrated)
fifo_len_rd_en  out  1  FIFO length read strobe (arbitrated)
fifo_data  in  DW  FIFO data_out, valid the cycle after fifo_rd_en
fifo_len  in  LENW  FIFO length_out, valid the cycle after fifo_len_rd_en
fifo_full  in  1  all bytes of the declared length are loaded
m_data  out  DW  transmit byte
m_valid  out  1  m_data valid; held with m_data stable until m_ready
m_ready  in  1  downstream accepts byte when m_valid and m_ready are both high
m_last  out  1  high with m_valid on the final byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last byte handshake
err  out  1  sticky error flag, cleared on the next accepted start
err_code  out  2  0 none, 1 not_ready, 2 bad_len, 3 timeout
byte_cnt  out  LENW  bytes handshaked in the current or last packet
host_blocked  out  1  one-cycle pulse when a host strobe arrives while not IDLE

Behaviour:
Reset:
- All outputs are 0 one edge after reset.
- State goes to IDLE and the counters clear.
- A reset mid-packet aborts without a done pulse. FIFO contents are untouched; the FIFO has its own reset.

States: IDLE, LEN_RD, LEN_WAIT, BYTE_RD, BYTE_WAIT, SEND, DONE.

IDLE:
- fifo_rd_en = host_rd_en & ~start.
- fifo_len_rd_en = host_len_rd_en & ~start.
- start with fifo_full=1: clear err/err_code/byte_cnt, go to LEN_RD. start has priority over a simultaneous host strobe; that host strobe is dropped and host_blocked pulses.
- start with fifo_full=0: err=1, err_code=1, stay IDLE.

LEN_RD:
- Drive fifo_len_rd_en=1 for one cycle, then go to LEN_WAIT.

LEN_WAIT:
- Latch fifo_len into len_q.
- len_q==0 or len_q>MAX_LEN: err=1, err_code=2, go to IDLE.
- Otherwise go to BYTE_RD.

BYTE_RD:
- Drive fifo_rd_en=1 for one cycle, then go to BYTE_WAIT.

BYTE_WAIT:
- Register fifo_data into m_data, set m_valid=1, go to SEND.

SEND:
- m_last = (byte_cnt == len_q-1).
- On handshake: m_valid=0, byte_cnt+1, stall counter cleared. Go to DONE if the new byte_cnt==len_q, else go to BYTE_RD.
- Each cycle with m_ready=0, the stall counter increments. When it reaches TIMEOUT_CYC: m_valid=0, err=1, err_code=3, go to IDLE. Remaining bytes stay in the FIFO.

DONE:
- done=1 for one cycle, then go to IDLE.

Timing and throughput:
- Latency from start to first m_valid is 5 cycles: LEN_RD, LEN_WAIT, BYTE_RD, BYTE_WAIT, then m_valid asserted entering SEND.
- Throughput is at most 1 byte per 3 cycles.

Arbitration and status rules:
- Any host strobe while not IDLE is dropped, never queued, and pulses host_blocked.
- start while busy is ignored and does not set err.
- byte_cnt holds its final value until the next accepted start.
- byte_cnt and stall counter widths are LENW and clog2(TIMEOUT_CYC+1). They are compared unsigned and never wrap, because MAX_LEN < 2^LENW.

Decomposition:
- Package tx_sched_pkg holds: state_t enum, err_code_t enum (ERR_NONE, ERR_NOT_READY, ERR_BAD_LEN, ERR_TIMEOUT), and the DW/LENW localparams.
- Single module. The stall timer stays inline; no sub-module is warranted.

Test Plan:
1. Load length 3 and bytes 01,02,03 (fifo_full=1), start, m_ready tied 1 -> m_data 01,02,03 in order; m_last only on 03; done pulses once; byte_cnt=3; err=0.
2. start with fifo_full=0 -> no FIFO strobes, busy stays 0, err=1, err_code=1. Then load a valid packet and start -> err clears.
3. Length 0, or length 65 with MAX_LEN=64 -> exactly one fifo_len_rd_en pulse, no fifo_rd_en, err_code=2, back to IDLE within 3 cycles.
4. m_ready low for 10 cycles on byte 02 -> m_data holds 02 stable with m_valid high throughout; after release, 03 follows; done pulses.
5. m_ready held low with TIMEOUT_CYC=255 -> m_valid drops after exactly 255 stall cycles, err_code=3, no done.
6. host_rd_en pulsed during SEND -> fifo_rd_en not driven by the host, host_blocked pulses. In IDLE, host_rd_en -> fifo_rd_en the same cycle. start+host_rd_en in the same cycle -> host dropped. Assert reset mid-SEND -> all outputs 0 next edge.
